timer_counter: RTL and testbench

//  Memory-mapped down-counting timer peripheral; source end of the interrupt path into the

---
 rtl/timer_counter_pkg.sv | 45 ++++
 rtl/timer_counter_if.sv | 32 +++
 rtl/timer_counter.sv | 142 ++++++++++++++
 tb/tb_timer_counter.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/timer_counter_pkg.sv
// Shared definitions for the memory-mapped down-counting timer.
//   - FSM state encodings (2-bit, legacy-compatible localparams)
//   - word offsets of the CPU-visible registers
//   - mode codes and CTRL bit positions
//   - default HWInt line that IRQ is wired to
//   - small decode helper for the mode field
package timer_counter_pkg;

  // FSM states
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_CNT  = 2'd2;
  localparam logic [1:0] ST_INT  = 2'd3;

  // Register word offsets
  localparam logic [1:0] OFS_CTRL   = 2'd0;
  localparam logic [1:0] OFS_PRESET = 2'd1;
  localparam logic [1:0] OFS_COUNT  = 2'd2;
  localparam logic [1:0] OFS_RSVD   = 2'd3;

  // CTRL.Mode codes; 2'b1x is decoded as one-shot
  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_AUTO    = 2'b01;

  // CTRL bit positions
  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IM_BIT   = 3;

  // HWInt input of the coprocessor that IRQ drives by default
  localparam int HWINT_IDX = 2;

  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

  // Only the exact auto-reload code reloads; every other code behaves as one-shot.
  function automatic logic is_auto_reload(input logic [1:0] mode);
    return (mode == MODE_AUTO);
  endfunction

endpackage

// File: rtl/timer_counter_if.sv
// CPU-side bus bundle of the timer peripheral.
//   addr  word offset (0=CTRL, 1=PRESET, 2=COUNT, 3=reserved)
//   we    write strobe, sampled on rising clk
//   din   write data
//   dout  combinational read data for addr
//   irq   interrupt request toward the coprocessor's HWInt input
// master: the CPU / data-bus bridge side. slave: the timer side.
interface timer_counter_if;

  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  modport master (
    output addr,
    output we,
    output din,
    input  dout,
    input  irq
  );

  modport slave (
    input  addr,
    input  we,
    input  din,
    output dout,
    output irq
  );

endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with interrupt output.
// The CPU programs CTRL / PRESET over the bus and can read COUNT back.
// On expiry irq_flag is set; IRQ = CTRL.IM & irq_flag.
//   one-shot    : IRQ is a level held until the next CTRL write.
//   auto-reload : IRQ is a 1-cycle pulse, period PRESET+3 (PRESET>=1).
// Ports
//   clk    sole clock, rising edge
//   reset  asynchronous, active-high; clears all state immediately
//   bus    timer_counter_if.slave (addr, we, din, dout, irq)
// Parameters
//   CNT_W       width of PRESET/COUNT (<= 32); dout zero-extends
//   PRESET_RST  PRESET value after reset
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for CTRL.En
// LOAD    | COUNT <= PRESET
// CNT     | counting down; expiry at COUNT<=1 sets irq_flag
// INT     | expiry cycle; one-shot clears En, auto-reload clears flag
module timer_counter
  import timer_counter_pkg::*;
#(
  parameter int              CNT_W      = 32,
  parameter logic [CNT_W-1:0] PRESET_RST = '0
) (
  input logic            clk,
  input logic            reset,
  timer_counter_if.slave bus
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [1:0]       state;
  ctrl_t            ctrl;
  logic [CNT_W-1:0] preset;
  logic [CNT_W-1:0] count;
  logic             irq_flag;

  logic wr_ctrl;
  logic wr_preset;
  logic expire;
  logic auto_mode;

  assign wr_ctrl   = bus.we && (bus.addr == OFS_CTRL);
  assign wr_preset = bus.we && (bus.addr == OFS_PRESET);
  assign auto_mode = is_auto_reload(ctrl.mode);

  // COUNT of 1 or 0 both finish the run, so PRESET=0 and PRESET=1 expire alike
  // and COUNT never wraps below zero.
  assign expire = (state == ST_CNT) && ctrl.en && (count <= ONE);

  // CTRL: a CPU write always beats the FSM's own En clear in INT.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl.im   <= 1'b0;
      ctrl.mode <= MODE_ONESHOT;
      ctrl.en   <= 1'b0;
    end else if (wr_ctrl) begin
      ctrl.im   <= bus.din[CTRL_IM_BIT];
      ctrl.mode <= bus.din[CTRL_MODE_MSB:CTRL_MODE_LSB];
      ctrl.en   <= bus.din[CTRL_EN_BIT];
    end else if ((state == ST_INT) && !auto_mode) begin
      ctrl.en <= 1'b0;
    end
  end

  // PRESET: a mid-count write only affects the next LOAD.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      preset <= PRESET_RST;
    end else if (wr_preset) begin
      preset <= bus.din[CNT_W-1:0];
    end
  end

  // irq_flag: any CTRL write clears it, even on the edge the counter expires.
  // Reading never clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_flag <= 1'b0;
    end else if (wr_ctrl) begin
      irq_flag <= 1'b0;
    end else if (expire) begin
      irq_flag <= 1'b1;
    end else if ((state == ST_INT) && auto_mode) begin
      irq_flag <= 1'b0;
    end
  end

  // FSM and COUNT
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      count <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ctrl.en) begin
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          count <= preset;
          state <= ST_CNT;
        end
        ST_CNT: begin
          if (!ctrl.en) begin
            // COUNT stays frozen and readable
            state <= ST_IDLE;
          end else if (expire) begin
            count <= '0;
            state <= ST_INT;
          end else begin
            count <= count - ONE;
          end
        end
        ST_INT: begin
          // Auto-reload goes through IDLE so the next LOAD follows one cycle later.
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Read mux: unused CTRL bits, the reserved offset and zero-extension read 0.
  always_comb begin
    bus.dout = '0;
    case (bus.addr)
      OFS_CTRL:   bus.dout = {28'd0, ctrl};
      OFS_PRESET: bus.dout = 32'(preset);
      OFS_COUNT:  bus.dout = 32'(count);
      OFS_RSVD:   bus.dout = '0;
      default:    bus.dout = '0;
    endcase
  end

  assign bus.irq = ctrl.im & irq_flag;

endmodule

// File: tb/tb_timer_counter.sv
module tb_timer_counter;
  import timer_counter_pkg::*;

  logic clk;
  logic reset;
  logic [7:0] hw_int;
  int total = 0;
  int bad   = 0;

  timer_counter_if bus ();

  timer_counter #(.CNT_W(32), .PRESET_RST(32'd0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  // IRQ lands on one HWInt line of the coprocessor
  assign hw_int = 8'(bus.irq) << HWINT_IDX;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.addr = a;
    bus.din  = d;
    bus.we   = 1'b1;
    tick();
    bus.we   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.dout;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model from the timing rules: CTRL written with En=1 at edge t0,
  // with m = max(PRESET,1) the first expiry is seen after edge t(2+m);
  // auto-reload repeats every m+3 edges. After edge tk (k>=2) COUNT sits at
  // phase j = k-2 of its run (mod period in auto-reload) and reads PRESET-j,
  // floored at 0.
  task automatic run_check(input int p, input logic [3:0] c, input int n);
    logic [31:0] d;
    int m, per, j;
    logic auto_r, im, exp_irq;
    logic [31:0] exp_cnt, exp_ctrl;
    wr(OFS_CTRL, 32'h0);
    tick();
    tick();
    wr(OFS_PRESET, 32'(p));
    wr(OFS_CTRL, {28'd0, c});
    m      = (p < 1) ? 1 : p;
    per    = m + 3;
    auto_r = (c[2:1] == 2'b01);
    im     = c[3];
    for (int k = 1; k <= n; k++) begin
      tick();
      if (auto_r)
        exp_irq = im && (k >= 2 + m) && (((k - 2 - m) % per) == 0);
      else
        exp_irq = im && (k >= 2 + m);
      check("irq", {31'd0, bus.irq}, {31'd0, exp_irq});
      check("hwint", {24'd0, hw_int}, {24'd0, 8'(exp_irq) << HWINT_IDX});
      if (k >= 2) begin
        j = auto_r ? ((k - 2) % per) : (k - 2);
        exp_cnt = (j <= p) ? 32'(p - j) : 32'd0;
        rd(OFS_COUNT, d);
        check("count", d, exp_cnt);
      end
      exp_ctrl = {28'd0, c};
      if (!auto_r && (k >= 3 + m)) exp_ctrl[0] = 1'b0;
      rd(OFS_CTRL, d);
      check("ctrl", d, exp_ctrl);
    end
  endtask

  initial begin
    logic [31:0] d;
    logic [3:0]  rc;
    int          rp;

    reset    = 1'b1;
    bus.addr = OFS_CTRL;
    bus.we   = 1'b0;
    bus.din  = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // reset state
    check("rst_irq", {31'd0, bus.irq}, 32'd0);
    rd(OFS_CTRL, d);   check("rst_ctrl", d, 32'd0);
    rd(OFS_PRESET, d); check("rst_preset", d, 32'd0);
    rd(OFS_COUNT, d);  check("rst_count", d, 32'd0);

    // one-shot PRESET=3, then clear by CTRL write
    run_check(3, 4'h9, 10);
    wr(OFS_CTRL, 32'h0);
    check("oneshot_clear", {31'd0, bus.irq}, 32'd0);

    // PRESET boundary values 0 and 1
    run_check(0, 4'h9, 8);
    run_check(1, 4'h9, 8);

    // auto-reload PRESET=3: pulses at t5, t11, t17
    run_check(3, 4'hB, 20);

    // mask: flag sets silently, CTRL write clears it, then unmasked re-run
    run_check(2, 4'h1, 10);
    wr(OFS_CTRL, 32'h8);
    check("mask_wrclr", {31'd0, bus.irq}, 32'd0);
    tick();
    check("mask_wrclr2", {31'd0, bus.irq}, 32'd0);
    run_check(2, 4'h9, 10);

    // stop: En=0 written on the edge that yields COUNT=5
    wr(OFS_CTRL, 32'h0); tick(); tick();
    wr(OFS_PRESET, 32'd10);
    wr(OFS_CTRL, 32'h1);
    repeat (6) tick();
    rd(OFS_COUNT, d); check("stop_k6", d, 32'd6);
    wr(OFS_CTRL, 32'h0);
    rd(OFS_COUNT, d); check("stop_k7", d, 32'd5);
    repeat (3) tick();
    rd(OFS_COUNT, d); check("stop_frozen", d, 32'd5);
    check("stop_irq", {31'd0, bus.irq}, 32'd0);
    wr(OFS_COUNT, 32'h55);
    rd(OFS_COUNT, d); check("count_ro", d, 32'd5);
    wr(OFS_RSVD, 32'hFFFF_FFFF);
    rd(OFS_RSVD, d); check("rsvd_zero", d, 32'd0);
    wr(OFS_CTRL, 32'hFFFF_FFF8);
    rd(OFS_CTRL, d); check("ctrl_upper", d, 32'h8);
    wr(OFS_CTRL, 32'h0);

    // PRESET write mid-count affects only the next LOAD
    tick(); tick();
    wr(OFS_PRESET, 32'd4);
    wr(OFS_CTRL, 32'h1);
    tick(); tick();
    rd(OFS_COUNT, d); check("pmid_k2", d, 32'd4);
    tick();
    wr(OFS_PRESET, 32'd7);
    rd(OFS_COUNT, d); check("pmid_k4", d, 32'd2);
    tick(); tick();
    rd(OFS_COUNT, d); check("pmid_k6", d, 32'd0);
    tick(); tick();
    wr(OFS_CTRL, 32'h1);
    tick(); tick();
    rd(OFS_COUNT, d); check("pmid_next", d, 32'd7);

    // collision: CTRL write lands on the one-shot INT exit edge
    wr(OFS_CTRL, 32'h0); tick(); tick();
    wr(OFS_PRESET, 32'd2);
    wr(OFS_CTRL, 32'h9);
    repeat (4) tick();
    check("col_irq_before", {31'd0, bus.irq}, 32'd1);
    wr(OFS_CTRL, 32'h9);
    rd(OFS_CTRL, d); check("col_ctrl", d, 32'h9);
    check("col_irq_after", {31'd0, bus.irq}, 32'd0);
    tick(); tick();
    rd(OFS_COUNT, d); check("col_restart", d, 32'd2);
    tick(); tick();
    check("col_irq_again", {31'd0, bus.irq}, 32'd1);

    // async reset while IRQ is high: takes effect without a clock edge
    #2;
    reset = 1'b1;
    #1;
    check("arst_irq", {31'd0, bus.irq}, 32'd0);
    rd(OFS_CTRL, d);   check("arst_ctrl", d, 32'd0);
    rd(OFS_COUNT, d);  check("arst_count", d, 32'd0);
    rd(OFS_PRESET, d); check("arst_preset", d, 32'd0);
    reset = 1'b0;
    tick();

    // async reset mid-count: nothing pending afterwards
    wr(OFS_PRESET, 32'd9);
    wr(OFS_CTRL, 32'h9);
    repeat (4) tick();
    rd(OFS_COUNT, d); check("arst2_pre", d, 32'd7);
    reset = 1'b1;
    #1;
    rd(OFS_COUNT, d); check("arst2_count", d, 32'd0);
    reset = 1'b0;
    repeat (12) tick();
    check("arst2_irq", {31'd0, bus.irq}, 32'd0);
    rd(OFS_COUNT, d); check("arst2_idle", d, 32'd0);

    // randomized runs over preset, mode (including 1x codes) and mask
    for (int r = 0; r < 10; r++) begin
      rp = int'($urandom_range(0, 6));
      rc = {1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'b1};
      run_check(rp, rc, 2 * (rp + 3) + 8);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
